alu_share_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU between two requesters: port 0 is the main pipeline execute stage; port 1 is the branch/compare helper.
- Round-robin arbitration, valid/ready handshake on each request port and on the single response port.
- Drives the ALU's A, B and ALUop inputs and captures its output into a one-entry response register, giving a 1-cycle latency.
- Sits between the execute-stage requesters and the ALU instance in the MIPS150 datapath.

---
 rtl/alu_share_arbiter_pkg.sv | 39 +++
 rtl/alu_share_arbiter_if.sv | 39 +++
 rtl/alu_share_arbiter_rr_arb2.sv | 38 +++
 rtl/alu_share_arbiter.sv | 110 +++++++++++
 tb/tb_alu_share_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALUop codes, requester ids
// and the two-way round-robin pick function.
package alu_share_arbiter_pkg;

    localparam logic [3:0] ALU_EQ  = 4'd0;
    localparam logic [3:0] ALU_NE  = 4'd1;
    localparam logic [3:0] ALU_LT  = 4'd2;
    localparam logic [3:0] ALU_LTU = 4'd3;
    localparam logic [3:0] ALU_GE  = 4'd4;
    localparam logic [3:0] ALU_GEU = 4'd5;
    localparam logic [3:0] ALU_ADD = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;
    localparam logic [3:0] ALU_XOR = 4'd8;
    localparam logic [3:0] ALU_OR  = 4'd9;
    localparam logic [3:0] ALU_AND = 4'd10;
    localparam logic [3:0] ALU_SLL = 4'd11;
    localparam logic [3:0] ALU_SRA = 4'd12;
    localparam logic [3:0] ALU_SRL = 4'd13;
    localparam logic [3:0] ALU_SUB = 4'd14;
    localparam logic [3:0] ALU_NOP = 4'd15;

    typedef logic req_id_t;

    localparam req_id_t REQ_PIPE = 1'b0;
    localparam req_id_t REQ_BR   = 1'b1;

    // Winner among two requesters; on contention the one not served last wins.
    function automatic req_id_t rr_pick(input logic [1:0] req, input req_id_t last);
        req_id_t w;
        case (req)
            2'b01:   w = REQ_PIPE;
            2'b10:   w = REQ_BR;
            2'b11:   w = ~last;
            default: w = REQ_PIPE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the result
// consumer and the sharing arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  resp_valid, resp_id, resp_data,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output resp_valid, resp_id, resp_data,
        input  resp_ready
    );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant logic; remembers the last winner so contention
// alternates. Reused for other two-port sharing blocks.
module rr_arb2
    import alu_share_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output req_id_t    winner_o
);
    req_id_t last_q;
    req_id_t last_d;

    // Grant decode: one-hot grant to the picked requester when enabled.
    always_comb begin
        winner_o = rr_pick(req_i, last_q);
        gnt_o    = 2'b00;
        last_d   = last_q;
        if (en_i && (req_i != 2'b00)) begin
            gnt_o[winner_o] = 1'b1;
            last_d          = winner_o;
        end else begin
            gnt_o  = 2'b00;
            last_d = last_q;
        end
    end

    // Last-winner register; reset favours requester 0 on the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_BR;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage and the branch
// helper, capturing the result into a one-entry response register.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arbiter_if.slave   bus,
    output logic [WIDTH-1:0]     alu_a_o,
    output logic [WIDTH-1:0]     alu_b_o,
    output logic [OPW-1:0]       alu_op_o,
    input  logic [WIDTH-1:0]     alu_out_i,
    output logic [CNT_W-1:0]     grant_cnt0_o,
    output logic [CNT_W-1:0]     grant_cnt1_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             resp_valid_q;
    req_id_t          resp_id_q;
    logic [WIDTH-1:0] resp_data_q;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic             en_s;
    logic [1:0]       gnt_s;
    req_id_t          winner_s;

    // Accept-and-drain in one cycle keeps throughput at one op per cycle;
    // nothing is granted while reset is asserted.
    assign en_s = (!resp_valid_q || bus.resp_ready) && !rst;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({bus.req1_valid, bus.req0_valid}),
        .en_i     (en_s),
        .gnt_o    (gnt_s),
        .winner_o (winner_s)
    );

    assign bus.req0_ready = gnt_s[0];
    assign bus.req1_ready = gnt_s[1];
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign grant_cnt0_o   = cnt0_q;
    assign grant_cnt1_o   = cnt1_q;

    // ALU operand mux; idle drives zeros and the NOP code so the ALU inputs stay deterministic.
    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = OPW'(ALU_NOP);
        if (gnt_s[0]) begin
            alu_a_o  = bus.req0_a;
            alu_b_o  = bus.req0_b;
            alu_op_o = bus.req0_op;
        end else if (gnt_s[1]) begin
            alu_a_o  = bus.req1_a;
            alu_b_o  = bus.req1_b;
            alu_op_o = bus.req1_op;
        end else begin
            alu_a_o  = '0;
            alu_b_o  = '0;
            alu_op_o = OPW'(ALU_NOP);
        end
    end

    // Saturating grant counters.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (gnt_s[0] && (cnt0_q != CNT_MAX)) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end else begin
            cnt0_d = cnt0_q;
        end
        if (gnt_s[1] && (cnt1_q != CNT_MAX)) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end else begin
            cnt1_d = cnt1_q;
        end
    end

    // Response register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= REQ_PIPE;
            resp_data_q  <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            if (gnt_s != 2'b00) begin
                resp_valid_q <= 1'b1;
                resp_id_q    <= winner_s;
                resp_data_q  <= alu_out_i;
            end else if (resp_valid_q && bus.resp_ready) begin
                resp_valid_q <= 1'b0;
            end else begin
                resp_valid_q <= resp_valid_q;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: directed vector table, hand-built corner sequences and
// random traffic checked against a behavioural model of the sharing rules.
module tb_alu_share_arbiter;
    localparam int WIDTH = 32;
    localparam int OPW   = 4;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [OPW-1:0]   alu_op;
    logic [CNT_W-1:0] cnt0, cnt1;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    alu_share_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_out_i    (alu_out),
        .grant_cnt0_o (cnt0),
        .grant_cnt1_o (cnt1)
    );

    always #5 clk = ~clk;

    // Stand-in for the datapath ALU.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd6:    return a + b;
            4'd14:   return a - b;
            4'd8:    return a ^ b;
            4'd9:    return a | b;
            4'd10:   return a & b;
            4'd11:   return a << b[4:0];
            4'd13:   return a >> b[4:0];
            default: return a ^ {b[15:0], b[31:16]} ^ {28'd0, op};
        endcase
    endfunction

    assign alu_out = ref_alu(alu_a, alu_b, alu_op);

    typedef struct {
        bit          rst;
        bit          v0;
        logic [31:0] a0, b0;
        logic [3:0]  op0;
        bit          v1;
        logic [31:0] a1, b1;
        logic [3:0]  op1;
        bit          rr;
        bit          e_rdy0, e_rdy1, e_rv, e_rid;
        logic [31:0] e_data;
        int          e_c0, e_c1;
    } vec_t;

    // Model state.
    bit          m_rv;
    int          m_id;
    logic [31:0] m_data;
    int          m_last;
    int          m_c[2];

    task automatic model_reset();
        m_rv = 1'b0; m_id = 0; m_data = 32'd0; m_last = 1; m_c[0] = 0; m_c[1] = 0;
    endtask

    function automatic int model_winner(vec_t v);
        if (v.rst) return -1;
        if (m_rv && !v.rr) return -1;
        if (v.v0 && v.v1) return (m_last == 0) ? 1 : 0;
        if (v.v0) return 0;
        if (v.v1) return 1;
        return -1;
    endfunction

    function automatic vec_t fill_model(vec_t v);
        vec_t r = v;
        int w = model_winner(v);
        r.e_rdy0 = (w == 0);
        r.e_rdy1 = (w == 1);
        r.e_rv   = m_rv;
        r.e_rid  = m_id[0];
        r.e_data = m_data;
        r.e_c0   = m_c[0];
        r.e_c1   = m_c[1];
        return r;
    endfunction

    function automatic vec_t mk(bit v0, logic [31:0] a0, logic [31:0] b0, logic [3:0] op0,
                                bit v1, logic [31:0] a1, logic [31:0] b1, logic [3:0] op1, bit rr,
                                bit e0, bit e1, bit erv, bit eid, logic [31:0] ed, int c0, int c1);
        vec_t v;
        v.rst = 1'b0; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.op0 = op0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1; v.op1 = op1; v.rr = rr;
        v.e_rdy0 = e0; v.e_rdy1 = e1; v.e_rv = erv; v.e_rid = eid; v.e_data = ed;
        v.e_c0 = c0; v.e_c1 = c1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock: drive, compare away from the edge, then advance the model.
    task automatic apply(input vec_t v);
        int w;
        logic [31:0] ea, eb;
        logic [3:0]  eop;
        @(negedge clk);
        rst = v.rst;
        bus.req0_valid = v.v0; bus.req0_a = v.a0; bus.req0_b = v.b0; bus.req0_op = v.op0;
        bus.req1_valid = v.v1; bus.req1_a = v.a1; bus.req1_b = v.b1; bus.req1_op = v.op1;
        bus.resp_ready = v.rr;
        #1;
        w = model_winner(v);
        ea = 32'd0; eb = 32'd0; eop = 4'hF;
        if (w == 0) begin ea = v.a0; eb = v.b0; eop = v.op0; end
        if (w == 1) begin ea = v.a1; eb = v.b1; eop = v.op1; end
        chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, v.e_rdy0});
        chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, v.e_rdy1});
        chk("resp_valid", {31'd0, bus.resp_valid}, {31'd0, v.e_rv});
        chk("resp_id",    {31'd0, bus.resp_id},    {31'd0, v.e_rid});
        chk("resp_data",  bus.resp_data, v.e_data);
        chk("grant_cnt0", {28'd0, cnt0}, v.e_c0);
        chk("grant_cnt1", {28'd0, cnt1}, v.e_c1);
        chk("alu_a",  alu_a, ea);
        chk("alu_b",  alu_b, eb);
        chk("alu_op", {28'd0, alu_op}, {28'd0, eop});
        @(posedge clk);
        cyc++;
        if (v.rst) begin
            model_reset();
        end else if (w >= 0) begin
            m_rv = 1'b1; m_id = w; m_last = w;
            m_data = (w == 0) ? ref_alu(v.a0, v.b0, v.op0) : ref_alu(v.a1, v.b1, v.op1);
            if (m_c[w] < CNT_MAX) m_c[w]++;
        end else if (m_rv && v.rr) begin
            m_rv = 1'b0;
        end
    endtask

    vec_t tbl[12];
    vec_t v;

    initial begin
        logic [31:0] ra0, rb0, ra1, rb1;
        logic [3:0]  rop0, rop1;
        bit          pend0, pend1;
        int          w;

        // Raw reset from an unknown state.
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        //         v0 a0        b0        op   v1 a1        b1        op   rr  r0 r1 rv id data          c0 c1
        tbl[0]  = mk(0, 32'd0,  32'd0,  4'd0,  0, 32'd0,    32'd0,    4'd0,  0,  0, 0, 0, 0, 32'd0,        0, 0);
        tbl[1]  = mk(1, 32'd5,  32'd7,  4'd6,  0, 32'd0,    32'd0,    4'd0,  1,  1, 0, 0, 0, 32'd0,        0, 0);
        tbl[2]  = mk(0, 32'd0,  32'd0,  4'd0,  0, 32'd0,    32'd0,    4'd0,  1,  0, 0, 1, 0, 32'd12,       1, 0);
        tbl[3]  = mk(1, 32'd3,  32'd5,  4'd6,  1, 32'd3,    32'd5,    4'd14, 1,  0, 1, 0, 0, 32'd12,       1, 0);
        tbl[4]  = mk(1, 32'd3,  32'd5,  4'd6,  1, 32'd3,    32'd5,    4'd14, 1,  1, 0, 1, 1, 32'hFFFFFFFE, 1, 1);
        tbl[5]  = mk(1, 32'd3,  32'd5,  4'd6,  1, 32'd3,    32'd5,    4'd14, 1,  0, 1, 1, 0, 32'd8,        2, 1);
        tbl[6]  = mk(0, 32'd0,  32'd0,  4'd0,  1, 32'hF0F0, 32'h0FF0, 4'd8,  1,  0, 1, 1, 1, 32'hFFFFFFFE, 2, 2);
        tbl[7]  = mk(1, 32'd3,  32'd5,  4'd6,  1, 32'hF0F0, 32'h0FF0, 4'd8,  0,  0, 0, 1, 1, 32'h0000FF00, 2, 3);
        tbl[8]  = mk(1, 32'd3,  32'd5,  4'd6,  1, 32'hF0F0, 32'h0FF0, 4'd8,  0,  0, 0, 1, 1, 32'h0000FF00, 2, 3);
        tbl[9]  = mk(1, 32'd3,  32'd5,  4'd6,  1, 32'hF0F0, 32'h0FF0, 4'd8,  1,  1, 0, 1, 1, 32'h0000FF00, 2, 3);
        tbl[10] = mk(0, 32'd0,  32'd0,  4'd0,  0, 32'd0,    32'd0,    4'd0,  1,  0, 0, 1, 0, 32'd8,        3, 3);
        tbl[11] = mk(0, 32'd0,  32'd0,  4'd0,  0, 32'd0,    32'd0,    4'd0,  1,  0, 0, 0, 0, 32'd8,        3, 3);
        for (int i = 0; i < 12; i++) apply(tbl[i]);

        // Saturation: 20 grants to requester 0.
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.rst = 1'b1;
        apply(fill_model(v));
        for (int i = 0; i < 20; i++) begin
            v = mk(1, i, 32'd1, 4'd6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            apply(fill_model(v));
        end
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'd20, 15, 0);
        apply(v);

        // Reset while a response is held under backpressure.
        v = mk(0, 0, 0, 0, 1, 32'd9, 32'd4, 4'd14, 1, 0, 0, 0, 0, 0, 0, 0);
        apply(fill_model(v));
        v = mk(1, 32'd1, 32'd2, 4'd6, 1, 32'd9, 32'd4, 4'd9, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(fill_model(v));
        v.rst = 1'b1;
        apply(fill_model(v));
        v = mk(1, 32'd1, 32'd2, 4'd6, 1, 32'd9, 32'd4, 4'd9, 0, 1, 0, 0, 0, 32'd0, 0, 0);
        apply(v);
        v = mk(1, 32'd1, 32'd2, 4'd6, 1, 32'd9, 32'd4, 4'd9, 1, 0, 1, 1, 0, 32'd3, 1, 0);
        apply(v);

        // Random traffic; operands held while a request waits.
        pend0 = 1'b0; pend1 = 1'b0;
        ra0 = 0; rb0 = 0; rop0 = 0; ra1 = 0; rb1 = 0; rop1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend0) begin ra0 = $urandom; rb0 = $urandom; rop0 = 4'($urandom_range(0, 15)); end
            if (!pend1) begin ra1 = $urandom; rb1 = $urandom; rop1 = 4'($urandom_range(0, 15)); end
            v = mk(pend0 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1), ra0, rb0, rop0,
                   pend1 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1), ra1, rb1, rop1,
                   ($urandom_range(0, 3) != 0), 0, 0, 0, 0, 0, 0, 0);
            v.rst = ($urandom_range(0, 59) == 0);
            w = model_winner(v);
            pend0 = v.v0 && (w != 0) && !v.rst;
            pend1 = v.v1 && (w != 1) && !v.rst;
            apply(fill_model(v));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
